// File: rtl/led_cube_anim_sequencer.sv
// Animation sequencer above the LED cube frame driver: frame pacing, ROM addressing,
// loop-mode auto-advance and a double-buffered stream frame store. Option: BRIGHTNESS_PWM_EN.
module led_cube_anim_sequencer #(
    parameter int FRAME_TICKS     = 1500000,
    parameter int FRAMES_PER_ANIM = 150,
    parameter int NUM_ANIM        = 7,
    parameter int LOOPS_PER_ANIM  = 5,
    parameter int BYTES_PER_FRAME = 64,
    localparam int AW = $clog2(BYTES_PER_FRAME),
    localparam int SW = $clog2(NUM_ANIM),
    localparam int FW = $clog2(FRAMES_PER_ANIM),
    localparam int RW = SW + FW + AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_animate_start,
    input  logic          i_animate_stop,
    input  logic [3:0]    i_mode,
    input  logic [SW-1:0] i_animation_sel,
    input  logic [3:0]    i_brightness,
    input  logic [AW-1:0] i_frame_byte_addr,
    input  logic          i_frame_done,
    output logic [RW-1:0] o_rom_addr,
    input  logic [7:0]    i_rom_data,
    input  logic          i_stream_wr,
    input  logic [7:0]    i_stream_data,
    output logic          o_stream_ready,
    output logic          o_frame_start,
    output logic [7:0]    o_data_to_latch,
    output logic          o_led_enable,
    output logic [SW-1:0] o_anim_idx
);

    // state   | meaning
    // IDLE    | waiting for animate_start
    // START   | one-cycle frame_start pulse, mode latched
    // DRIVE   | frame displayed for FRAME_TICKS cycles
    // ADVANCE | step frame/loop/animation, swap stream buffers
    typedef enum logic [1:0] {S_IDLE, S_START, S_DRIVE, S_ADVANCE} state_t;

    localparam int TW = $clog2(FRAME_TICKS);
    localparam int LW = (LOOPS_PER_ANIM > 1) ? $clog2(LOOPS_PER_ANIM) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [FW-1:0]   r_frame_idx;
    logic [LW-1:0]   r_loop_cnt;
    logic [SW-1:0]   r_anim_idx;
    logic [3:0]      r_mode_q;
    logic [7:0]      r_done_cnt;
    logic [AW-1:0]   r_wr_ptr;
    logic            r_back_full;
    logic            r_front;
    logic [7:0]      r_buf [2][BYTES_PER_FRAME];

    logic            w_timer_last;
    logic            w_frame_wrap;
    logic            w_wr_en;
    logic            w_sel_ok;
    logic [SW-1:0]   w_anim_field;
    logic            w_unused;

    assign w_timer_last = (r_timer == TW'(FRAME_TICKS - 1));
    assign w_frame_wrap = (r_frame_idx == FW'(FRAMES_PER_ANIM - 1));
    assign w_wr_en      = i_stream_wr & ~r_back_full;
    assign w_sel_ok     = (int'(i_animation_sel) < NUM_ANIM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_animate_start) w_state_nxt = S_START;
            S_START:   w_state_nxt = S_DRIVE;
            S_DRIVE:   if (w_timer_last) w_state_nxt = S_ADVANCE;
            S_ADVANCE: w_state_nxt = S_START;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (i_animate_stop) w_state_nxt = S_IDLE;
    end

    // mode is captured on entry to START so the pulse cycle already addresses the new mode
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timer     <= '0;
            r_frame_idx <= '0;
            r_loop_cnt  <= '0;
            r_anim_idx  <= '0;
            r_mode_q    <= '0;
        end else if (i_animate_stop) begin
            r_timer     <= '0;
            r_frame_idx <= '0;
            r_loop_cnt  <= '0;
        end else begin
            if (w_state_nxt == S_START) r_mode_q <= i_mode;
            case (r_state)
                S_START: r_timer <= '0;
                S_DRIVE: r_timer <= w_timer_last ? '0 : r_timer + TW'(1);
                S_ADVANCE: begin
                    r_frame_idx <= w_frame_wrap ? '0 : r_frame_idx + FW'(1);
                    if (r_mode_q != 4'h1) begin
                        r_loop_cnt <= '0;
                    end else if (w_frame_wrap) begin
                        if (r_loop_cnt == LW'(LOOPS_PER_ANIM - 1)) begin
                            r_loop_cnt <= '0;
                            r_anim_idx <= (r_anim_idx == SW'(NUM_ANIM - 1)) ? '0
                                                                           : r_anim_idx + SW'(1);
                        end else begin
                            r_loop_cnt <= r_loop_cnt + LW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_done_cnt <= '0;
        else if (r_state == S_START) r_done_cnt <= '0;
        else if (i_frame_done)       r_done_cnt <= r_done_cnt + 8'd1;
    end

    // write and swap never coincide: writes need !back_full, the swap needs back_full
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_back_full <= 1'b0;
            r_front     <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_wr_ptr == AW'(BYTES_PER_FRAME - 1)) r_back_full <= 1'b1;
            end
            if (r_state == S_ADVANCE && r_back_full) begin
                r_front     <= ~r_front;
                r_back_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_buf[~r_front][r_wr_ptr] <= i_stream_data;
    end

    assign w_anim_field = (r_mode_q == 4'h2) ? i_animation_sel : r_anim_idx;
    assign o_rom_addr   = {w_anim_field, r_frame_idx, i_frame_byte_addr};

    always_comb begin
        o_data_to_latch = 8'h00;
        case (r_mode_q)
            4'h1:    o_data_to_latch = i_rom_data;
            4'h2:    o_data_to_latch = w_sel_ok ? i_rom_data : 8'h00;
            4'h3:    o_data_to_latch = r_buf[r_front][i_frame_byte_addr];
            4'hF:    o_data_to_latch = 8'hFF;
            default: o_data_to_latch = 8'h00;
        endcase
    end

    assign o_frame_start  = (r_state == S_START);
    assign o_stream_ready = ~r_back_full;
    assign o_anim_idx     = r_anim_idx;

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] r_pwm_cnt;
    logic       r_led_enable;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm_cnt    <= '0;
            r_led_enable <= 1'b0;
        end else begin
            r_pwm_cnt    <= (r_pwm_cnt == 4'd14) ? 4'd0 : r_pwm_cnt + 4'd1;
            r_led_enable <= (r_pwm_cnt < i_brightness);
        end
    end

    assign o_led_enable = r_led_enable;
    assign w_unused     = ^r_done_cnt;
`else
    assign o_led_enable = 1'b1;
    assign w_unused     = ^{r_done_cnt, i_brightness};
`endif

endmodule

// File: tb/tb_led_cube_anim_sequencer.sv
// Scoreboard bench for led_cube_anim_sequencer with small parameters (4-tick frames,
// 3 frames/anim, 2 animations, 2 loops, 4-byte frames).
module tb_led_cube_anim_sequencer;
    localparam int FT = 4, FPA = 3, NA = 2, LPA = 2, BPF = 4;
    localparam int AW = 2, SW = 1, FW = 2, RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [3:0]    mode = 4'h0;
    logic [3:0]    brightness = 4'h0;
    logic [SW-1:0] sel = '0;
    logic [AW-1:0] fba = '0;
    logic          fdone = 1'b0;
    logic [RW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          swr = 1'b0;
    logic [7:0]    sdata = 8'h00;
    logic          sready, fstart, led;
    logic [7:0]    dtl;
    logic [SW-1:0] anim;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [SW-1:0] anim;
        logic [FW-1:0] frame;
    } exp_t;
    exp_t       fq[$];
    logic [7:0] bq[$];

    led_cube_anim_sequencer #(
        .FRAME_TICKS(FT), .FRAMES_PER_ANIM(FPA), .NUM_ANIM(NA),
        .LOOPS_PER_ANIM(LPA), .BYTES_PER_FRAME(BPF)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_animate_start(start), .i_animate_stop(stop),
        .i_mode(mode), .i_animation_sel(sel), .i_brightness(brightness),
        .i_frame_byte_addr(fba), .i_frame_done(fdone), .o_rom_addr(rom_addr),
        .i_rom_data(rom_data), .i_stream_wr(swr), .i_stream_data(sdata),
        .o_stream_ready(sready), .o_frame_start(fstart), .o_data_to_latch(dtl),
        .o_led_enable(led), .o_anim_idx(anim)
    );

    always #5 clk = ~clk;

    // ROM model: content is a simple function of the address
    assign rom_data = 8'h40 + {3'b000, rom_addr};

    task automatic wait_fs(input int budget, output int cyc, output bit ok);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (fstart === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        swr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic exp_led;
`ifdef BRIGHTNESS_PWM_EN
        exp_led = 1'b0;
`else
        exp_led = 1'b1;
`endif
        rst_n = 1'b0;
        fba = '0;
        #1;
        checks++; if (fstart !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b want=0", fstart); end
        checks++; if (sready !== 1'b1) begin errors++; $display("FAIL reset_stream_ready got=%b want=1", sready); end
        checks++; if (anim !== '0) begin errors++; $display("FAIL reset_anim_idx got=%0d want=0", anim); end
        checks++; if (dtl !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", dtl); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr got=%h want=00", rom_addr); end
        checks++; if (led !== exp_led) begin errors++; $display("FAIL reset_led_enable got=%b want=%b", led, exp_led); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_selected_rom();
        exp_t e;
        int   cyc;
        bit   ok;
        logic [7:0] exp_d;
        mode = 4'h2;
        sel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e.anim = 1'b1;
            e.frame = FW'(k % FPA);
            fq.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (fstart !== 1'b1) begin errors++; $display("FAIL sel_first_frame_start got=%b want=1", fstart); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                wait_fs(20, cyc, ok);
                checks++; if (!ok) begin errors++; $display("FAIL sel_frame_start_timeout got=none want=pulse"); end
                checks++; if (cyc != FT + 2) begin errors++; $display("FAIL sel_interval got=%0d want=%0d", cyc, FT + 2); end
            end
            e = fq.pop_front();
            fba = AW'(k);
            #1;
            exp_d = 8'h40 + {3'b000, e.anim, e.frame, fba};
            checks++; if (rom_addr[3:2] !== e.frame) begin errors++; $display("FAIL sel_frame_field got=%0d want=%0d", rom_addr[3:2], e.frame); end
            checks++; if (rom_addr[4] !== e.anim) begin errors++; $display("FAIL sel_anim_field got=%0d want=%0d", rom_addr[4], e.anim); end
            checks++; if (dtl !== exp_d) begin errors++; $display("FAIL sel_data got=%h want=%h", dtl, exp_d); end
        end
        pulse_stop();
    endtask

    task automatic test_stop();
        int cyc;
        bit ok;
        int seen;
        mode = 4'h2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_fs(20, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_setup_timeout got=none want=pulse"); end
        checks++; if (rom_addr[3:2] !== 2'd1) begin errors++; $display("FAIL stop_setup_frame got=%0d want=1", rom_addr[3:2]); end
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        checks++; if (fstart !== 1'b0) begin errors++; $display("FAIL stop_frame_start got=%b want=0", fstart); end
        checks++; if (rom_addr[3:2] !== 2'd0) begin errors++; $display("FAIL stop_frame_idx got=%0d want=0", rom_addr[3:2]); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fstart === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL stop_held_pulses got=%0d want=0", seen); end
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loop();
        exp_t e;
        int   cyc;
        bit   ok;
        do_reset();
        mode = 4'h1;
        for (int f = 0; f <= 12; f++) begin
            e.anim = SW'((f / (FPA * LPA)) % NA);
            e.frame = FW'(f % FPA);
            fq.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int f = 0; f <= 12; f++) begin
            if (f > 0) begin
                wait_fs(20, cyc, ok);
                checks++; if (!ok) begin errors++; $display("FAIL loop_timeout frame=%0d got=none want=pulse", f); end
            end
            e = fq.pop_front();
            checks++; if (anim !== e.anim) begin errors++; $display("FAIL loop_anim_idx frame=%0d got=%0d want=%0d", f, anim, e.anim); end
            checks++; if (rom_addr[4] !== e.anim || rom_addr[3:2] !== e.frame)
                begin errors++; $display("FAIL loop_rom_addr frame=%0d got=%h want=%0d/%0d", f, rom_addr, e.anim, e.frame); end
        end
        pulse_stop();
    endtask

    task automatic test_stream();
        int cyc;
        bit ok;
        logic [7:0] exp_b;
        mode = 4'h3;
        for (int i = 0; i < BPF; i++) begin
            swr = 1'b1;
            sdata = 8'hA0 + 8'(i);
            bq.push_back(sdata);
            @(negedge clk);
        end
        swr = 1'b0;
        checks++; if (sready !== 1'b0) begin errors++; $display("FAIL stream_full_ready got=%b want=0", sready); end
        swr = 1'b1;
        sdata = 8'hEE;
        @(negedge clk);
        swr = 1'b0;
        checks++; if (sready !== 1'b0) begin errors++; $display("FAIL stream_ignored_ready got=%b want=0", sready); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_fs(20, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stream_timeout got=none want=pulse"); end
        checks++; if (sready !== 1'b1) begin errors++; $display("FAIL stream_swap_ready got=%b want=1", sready); end
        for (int a = 0; a < BPF; a++) begin
            fba = AW'(a);
            #1;
            exp_b = bq.pop_front();
            checks++; if (dtl !== exp_b) begin errors++; $display("FAIL stream_byte addr=%0d got=%h want=%h", a, dtl, exp_b); end
        end
        pulse_stop();
    endtask

    task automatic test_async_reset_all_on();
        mode = 4'hF;
        for (int i = 0; i < BPF; i++) begin
            swr = 1'b1;
            sdata = 8'h10 + 8'(i);
            @(negedge clk);
        end
        swr = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dtl !== 8'hFF) begin errors++; $display("FAIL allon_data got=%h want=ff", dtl); end
        checks++; if (sready !== 1'b0) begin errors++; $display("FAIL allon_ready_pre got=%b want=0", sready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (sready !== 1'b1) begin errors++; $display("FAIL async_ready got=%b want=1", sready); end
        checks++; if (dtl !== 8'h00) begin errors++; $display("FAIL async_data got=%h want=00", dtl); end
        checks++; if (fstart !== 1'b0) begin errors++; $display("FAIL async_frame_start got=%b want=0", fstart); end
        checks++; if (rom_addr[3:2] !== 2'd0) begin errors++; $display("FAIL async_frame_idx got=%0d want=0", rom_addr[3:2]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (fstart !== 1'b0) begin errors++; $display("FAIL async_stays_idle got=%b want=0", fstart); end
    endtask

    task automatic test_brightness();
        int hi;
        int exp_hi;
`ifdef BRIGHTNESS_PWM_EN
        exp_hi = 5;
`else
        exp_hi = 15;
`endif
        brightness = 4'd5;
        repeat (3) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (led === 1'b1) hi++;
        end
        checks++; if (hi != exp_hi) begin errors++; $display("FAIL led_enable_duty got=%0d want=%0d", hi, exp_hi); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_selected_rom();
        test_stop();
        test_loop();
        test_stream();
        test_async_reset_all_on();
        test_brightness();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
